// File: rtl/ftoi_converter_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ftoi_converter_pipe_if
// Description : Operand/result bundle for the pipelined float-to-integer
//               converter. It carries the upstream valid/ready handshake,
//               the unpacked operand, the downstream valid/ready handshake,
//               the pipeline flush and the integer result with its flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Modports
//   slave  : converter side (takes operands, produces results)
//   master : environment side (supplies operands, consumes results)
// Signals
//   flush                      pipeline kill
//   valid_in / ready_out       operand handshake
//   valid_out / ready_in       result handshake
//   op, rm                     operation and rounding mode
//   man_a, exp_a               mantissa (with hidden bit), biased exponent
//   sgn_a, zero_a, inf_a,
//   sNaN_a, qNaN_a             sign and class flags
//   frac_bits                  fixed-point scale (FTOI_FIXED_POINT_EN only)
//   int_out, IV, IE            result, invalid flag, inexact flag
// Optional feature macro: FTOI_FIXED_POINT_EN
// ============================================================================
interface ftoi_converter_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
);
    logic                     flush;
    logic                     valid_in;
    logic                     ready_out;
    logic                     valid_out;
    logic                     ready_in;
    logic [4:0]               op;
    logic [2:0]               rm;
    logic [MAN_W:0]           man_a;
    logic [EXP_W-1:0]         exp_a;
    logic                     sgn_a;
    logic                     zero_a;
    logic                     inf_a;
    logic                     sNaN_a;
    logic                     qNaN_a;
`ifdef FTOI_FIXED_POINT_EN
    logic [$clog2(INT_W)-1:0] frac_bits;
`endif
    logic [INT_W-1:0]         int_out;
    logic                     IV;
    logic                     IE;

    modport slave (
`ifdef FTOI_FIXED_POINT_EN
        input  frac_bits,
`endif
        input  flush, valid_in, ready_in, op, rm, man_a, exp_a,
        input  sgn_a, zero_a, inf_a, sNaN_a, qNaN_a,
        output ready_out, valid_out, int_out, IV, IE
    );

    modport master (
`ifdef FTOI_FIXED_POINT_EN
        output frac_bits,
`endif
        output flush, valid_in, ready_in, op, rm, man_a, exp_a,
        output sgn_a, zero_a, inf_a, sNaN_a, qNaN_a,
        input  ready_out, valid_out, int_out, IV, IE
    );
endinterface
`default_nettype wire

// File: rtl/ftoi_converter_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ftoi_converter_pipe
// Description : Two-stage pipelined float-to-integer converter (FCVT.W/WU
//               style) with per-stage valid/ready backpressure.
//               S1 classifies the operand and aligns it into an integer part
//               M plus round (R) and sticky (S) bits.
//               S2 applies the rounding increment, checks the rounded
//               magnitude against the target range and saturates.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : ftoi_converter_pipe_if.slave (handshakes, operand, result, flush)
// Parameters
//   EXP_W  : exponent width (bias = 2^(EXP_W-1)-1)
//   MAN_W  : stored fraction width (man_a is MAN_W+1 bits with hidden bit)
//   INT_W  : result width, 16..64
// Optional feature macro: FTOI_FIXED_POINT_EN
//   When defined the operand is scaled by 2^frac_bits before rounding.
// ============================================================================
module ftoi_converter_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    ftoi_converter_pipe_if.slave bus
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    localparam logic [4:0] c_FPU_OP_CVTFI = 5'd24;
    localparam logic [4:0] c_FPU_OP_CVTFU = 5'd25;

    localparam logic [2:0] c_FPU_RM_RNE = 3'd0;
    localparam logic [2:0] c_FPU_RM_RTZ = 3'd1;
    localparam logic [2:0] c_FPU_RM_RDN = 3'd2;
    localparam logic [2:0] c_FPU_RM_RUP = 3'd3;
    localparam logic [2:0] c_FPU_RM_RMM = 3'd4;

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int FB_W = $clog2(INT_W);
`ifdef FTOI_FIXED_POINT_EN
    // Unbiased exponent must also hold the added scale without wrapping.
    localparam int E_W  = EXP_W + FB_W + 2;
`else
    localparam int E_W  = EXP_W + 2;
`endif
    // Alignment vector: INT_W+1 integer bits above MAN_W+1 fraction bits.
    localparam int V_W  = MAN_W + INT_W + 2;

    localparam logic        [E_W-1:0] c_BIAS  = E_W'((1 << (EXP_W - 1)) - 1);
    localparam logic        [E_W-1:0] c_ONE   = E_W'(1);
    localparam logic signed [E_W-1:0] c_E_OVF = E_W'(INT_W + 1);
    localparam logic signed [E_W-1:0] c_E_MIN = '1;   // -1

    // Magnitude limits on the rounded value (INT_W+1 bits).
    localparam logic [INT_W:0] c_LIM_SPOS = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0] c_LIM_SNEG = {2'b01, {(INT_W-1){1'b0}}};
    localparam logic [INT_W:0] c_LIM_UPOS = {1'b0, {INT_W{1'b1}}};

    // Saturation results.
    localparam logic [INT_W-1:0] c_SAT_SPOS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] c_SAT_SNEG = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] c_SAT_UPOS = {INT_W{1'b1}};
    localparam logic [INT_W-1:0] c_SAT_UNEG = '0;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic r1_valid;
    logic r2_valid;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_op_ok;
    logic w_accept;

    assign w_s2_adv = !r2_valid || bus.ready_in;
    assign w_s1_adv = !r1_valid || w_s2_adv;
    assign w_op_ok  = (bus.op == c_FPU_OP_CVTFI) || (bus.op == c_FPU_OP_CVTFU);
    assign w_accept = bus.valid_in && w_s1_adv && w_op_ok;

    assign bus.ready_out = w_s1_adv;

    // ------------------------------------------------------------------
    // S1: classify and align
    // ------------------------------------------------------------------
    logic signed [E_W-1:0]   w_e;
    logic        [E_W-1:0]   w_sh;
    logic        [V_W-1:0]   w_v;
    logic                    w_povf;
    logic                    w_tiny;
    logic        [INT_W:0]   w_m;
    logic                    w_r;
    logic                    w_s;

`ifdef FTOI_FIXED_POINT_EN
    // frac_bits only shifts the binary point, so it is folded into the
    // exponent here and travels down the pipe inside M/R/S.
    assign w_e = $signed({{(E_W-EXP_W){1'b0}}, bus.exp_a}
                       + {{(E_W-FB_W){1'b0}}, bus.frac_bits} - c_BIAS);
`else
    assign w_e = $signed({{(E_W-EXP_W){1'b0}}, bus.exp_a} - c_BIAS);
`endif

    assign w_povf = (w_e >= c_E_OVF);
    assign w_tiny = (w_e <  c_E_MIN);

    // Shift by e+1 places the mantissa so bit MAN_W is the first fraction
    // bit. Out-of-range shift amounts are overridden below, so wrap-around
    // of a negative e into a large unsigned shift is harmless.
    assign w_sh = w_e + c_ONE;
    assign w_v  = {{(INT_W+1){1'b0}}, bus.man_a} << w_sh;

    always_comb begin
        w_m = w_v[V_W-1 -: INT_W+1];
        w_r = w_v[MAN_W];
        w_s = |w_v[MAN_W-1:0];
        if (w_tiny) begin
            // |x| < 0.5: everything is sticky unless the operand is zero.
            w_m = '0;
            w_r = 1'b0;
            w_s = !bus.zero_a;
        end
    end

    logic [2:0]     r1_rm;
    logic           r1_sgn;
    logic           r1_uns;
    logic           r1_zero;
    logic           r1_inf;
    logic           r1_nan;
    logic           r1_povf;
    logic [INT_W:0] r1_m;
    logic           r1_r;
    logic           r1_s;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r1_valid <= w_accept;
            if (w_accept) begin
                r1_rm   <= bus.rm;
                r1_sgn  <= bus.sgn_a;
                r1_uns  <= (bus.op == c_FPU_OP_CVTFU);
                r1_zero <= bus.zero_a;
                r1_inf  <= bus.inf_a;
                r1_nan  <= bus.sNaN_a || bus.qNaN_a;
                r1_povf <= w_povf;
                r1_m    <= w_m;
                r1_r    <= w_r;
                r1_s    <= w_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: round, range check, saturate
    // ------------------------------------------------------------------
    logic             w_inc;
    logic [INT_W+1:0] w_mr_ext;
    logic             w_carry;
    logic [INT_W:0]   w_mr;
    logic             w_in_range;
    logic             w_ovf;
    logic [INT_W-1:0] w_sat_pos;
    logic [INT_W-1:0] w_sat_neg;
    logic [INT_W-1:0] w_res;
    logic             w_iv;
    logic             w_ie;

    always_comb begin
        w_inc = 1'b0;
        case (r1_rm)
            c_FPU_RM_RNE: w_inc = r1_r & (r1_s | r1_m[0]);
            c_FPU_RM_RTZ: w_inc = 1'b0;
            c_FPU_RM_RDN: w_inc = r1_sgn & (r1_r | r1_s);
            c_FPU_RM_RUP: w_inc = !r1_sgn & (r1_r | r1_s);
            c_FPU_RM_RMM: w_inc = r1_r;
            default:      w_inc = 1'b0;
        endcase
    end

    // One extra bit catches M = all-ones rounding up, which would otherwise
    // wrap to zero and look in range.
    assign w_mr_ext = {1'b0, r1_m} + {{(INT_W+1){1'b0}}, w_inc};
    assign w_carry  = w_mr_ext[INT_W+1];
    assign w_mr     = w_mr_ext[INT_W:0];

    always_comb begin
        if (r1_uns) begin
            w_in_range = r1_sgn ? (w_mr == '0) : (w_mr <= c_LIM_UPOS);
        end else begin
            w_in_range = r1_sgn ? (w_mr <= c_LIM_SNEG) : (w_mr <= c_LIM_SPOS);
        end
    end

    assign w_ovf     = r1_povf || w_carry || !w_in_range;
    assign w_sat_pos = r1_uns ? c_SAT_UPOS : c_SAT_SPOS;
    assign w_sat_neg = r1_uns ? c_SAT_UNEG : c_SAT_SNEG;

    always_comb begin
        w_res = '0;
        w_iv  = 1'b0;
        w_ie  = 1'b0;
        if (r1_zero) begin
            w_res = '0;
        end else if (r1_nan || (r1_inf && !r1_sgn)) begin
            // NaN saturates positive regardless of its sign bit.
            w_res = w_sat_pos;
            w_iv  = 1'b1;
        end else if (r1_inf) begin
            w_res = w_sat_neg;
            w_iv  = 1'b1;
        end else if (w_ovf) begin
            w_res = r1_sgn ? w_sat_neg : w_sat_pos;
            w_iv  = 1'b1;
        end else begin
            // Unsigned negatives reaching here have Mr == 0, so no negate.
            w_res = (r1_sgn && !r1_uns) ? -w_mr[INT_W-1:0] : w_mr[INT_W-1:0];
            w_ie  = r1_r | r1_s;
        end
    end

    logic [INT_W-1:0] r2_int;
    logic             r2_iv;
    logic             r2_ie;

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r2_valid <= 1'b0;
            r2_int   <= '0;
            r2_iv    <= 1'b0;
            r2_ie    <= 1'b0;
        end else if (w_s2_adv) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_int <= w_res;
                r2_iv  <= w_iv;
                r2_ie  <= w_ie;
            end else begin
                // A bubble clears the result so idle outputs read as zero.
                r2_int <= '0;
                r2_iv  <= 1'b0;
                r2_ie  <= 1'b0;
            end
        end
    end

    assign bus.valid_out = r2_valid;
    assign bus.int_out   = r2_int;
    assign bus.IV        = r2_iv;
    assign bus.IE        = r2_ie;

endmodule
`default_nettype wire
